mem_bus_arbiter: RTL

//   Upstream master for mem_bus. Arbitrates CPU instruction-fetch and load/store requests

---
 rtl/mem_bus_pkg.sv | 33 +++
 rtl/mem_bus_arbiter_if.sv | 27 ++
 rtl/mem_bus_arbiter_load_extend.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the mem_bus upstream arbiter: transfer size
//   encodings, FSM state type, IO/RAM select bit positions (counted down
//   from the top of the bus address), and the size-to-byte-count helper.
package mem_bus_pkg;

  // ls_size encodings; the fourth code is reserved and behaves as a word
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Select bits sit at bus_addr[ADDR_SIZE - <offset>]
  localparam int IO_SEL_FROM_TOP  = 1;
  localparam int RAM_SEL_FROM_TOP = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Byte count driven on bus_num_bytes for a given size code
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   The level-held request port of mem_bus.
//   master modport: the arbiter (drives address/size/strobe/data/start).
//   slave modport : mem_bus (drives done and read data).
//   Signals: bus_addr[ADDR_SIZE], bus_num_bytes[3], bus_is_write, bus_wdata[32],
//            bus_start, bus_done, bus_rdata[32].
interface mem_bus_arbiter_if #(
  parameter int ADDR_SIZE = 18
);
  logic [ADDR_SIZE-1:0] bus_addr;
  logic [2:0]           bus_num_bytes;
  logic                 bus_is_write;
  logic [31:0]          bus_wdata;
  logic                 bus_start;
  logic                 bus_done;
  logic [31:0]          bus_rdata;

  modport master (
    output bus_addr, bus_num_bytes, bus_is_write, bus_wdata, bus_start,
    input  bus_done, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_num_bytes, bus_is_write, bus_wdata, bus_start,
    output bus_done, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_load_extend.sv
// load_extend
//   Combinational size/sign extension of right-justified load data.
//   Ports: data_i[32] raw data, size_i[2] size code, unsigned_i 1 = zero-extend,
//          data_o[32] extended data. Word and reserved sizes pass through.
module load_extend
  import mem_bus_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Replicate the top bit of the addressed width unless zero-extending
  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & data_i[7]}},  data_i[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Upstream master for mem_bus. Arbitrates load/store (fixed priority) and
//   instruction fetch onto the single level-held request port, sizes the
//   transfer, extends load data and forces one start-low RELEASE cycle
//   between transactions so mem_bus can return to its parse state.
//   Optional build macro: BUS_TIMEOUT_EN (abort a request after
//   TIMEOUT_CYCLES cycles in REQ with bus_err pulsed alongside the ack).
//   Ports: clk, rst_n (synchronous, active-low);
//          fetch side  if_req/if_addr -> if_ack/if_rdata;
//          data side   ls_req/ls_addr/ls_we/ls_size/ls_unsigned/ls_wdata -> ls_ack/ls_rdata;
//          bus_err; bus (mem_bus_arbiter_if.master) towards mem_bus.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_SIZE      = 18,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        bus_err,
  mem_bus_arbiter_if.master bus
);

  state_e               state_q, state_d;
  logic                 start_q, start_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [2:0]           nbytes_q, nbytes_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 is_fetch_q, is_fetch_d;
  logic [1:0]           size_q, size_d;
  logic                 unsigned_q, unsigned_d;
  logic                 if_ack_q, if_ack_d;
  logic                 ls_ack_q, ls_ack_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic [31:0]          ls_rdata_q, ls_rdata_d;
  logic [31:0]          ext_s;
  logic                 timeout_s;
  logic                 unused_s;

  // Address bits above the bus width are dropped on purpose
  assign unused_s = ^{if_addr[31:ADDR_SIZE], ls_addr[31:ADDR_SIZE]};

  load_extend u_load_extend (
    .data_i     (bus.bus_rdata),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_s)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Last REQ cycle of the budget: abort unless done arrives in it
  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycle counter, zero outside REQ so it is clear on every REQ entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_q <= {CNT_W{1'b0}};
      end
      err_q <= (state_q == ST_REQ) && !bus.bus_done && timeout_s;
    end
  end

  assign bus_err = err_q;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      addr_q     <= {ADDR_SIZE{1'b0}};
      nbytes_q   <= 3'd4;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      is_fetch_q <= 1'b0;
      size_q     <= SZ_WORD;
      unsigned_q <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      if_rdata_q <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      nbytes_q   <= nbytes_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      is_fetch_q <= is_fetch_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for done/timeout in REQ, one RELEASE cycle
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    addr_d     = addr_q;
    nbytes_d   = nbytes_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    is_fetch_d = is_fetch_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (ls_req) begin
          addr_d     = ls_addr[ADDR_SIZE-1:0];
          nbytes_d   = size_to_bytes(ls_size);
          we_d       = ls_we;
          wdata_d    = ls_wdata;
          is_fetch_d = 1'b0;
          size_d     = ls_size;
          unsigned_d = ls_unsigned;
          start_d    = 1'b1;
          state_d    = ST_REQ;
        end else if (if_req) begin
          addr_d     = if_addr[ADDR_SIZE-1:0];
          nbytes_d   = 3'd4;
          we_d       = 1'b0;
          wdata_d    = 32'd0;
          is_fetch_d = 1'b1;
          size_d     = SZ_WORD;
          unsigned_d = 1'b1;
          start_d    = 1'b1;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (bus.bus_done) begin
          start_d = 1'b0;
          state_d = ST_RELEASE;
          if (is_fetch_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.bus_rdata;
          end else begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = we_q ? 32'd0 : ext_s;
          end
        end else if (timeout_s) begin
          // Aborted transfer: ack with zero data so the requester does not hang
          start_d = 1'b0;
          state_d = ST_RELEASE;
          if (is_fetch_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = 32'd0;
          end else begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = 32'd0;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_RELEASE: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.bus_addr      = addr_q;
  assign bus.bus_num_bytes = nbytes_q;
  assign bus.bus_is_write  = we_q;
  assign bus.bus_wdata     = wdata_q;
  assign bus.bus_start     = start_q;
  assign if_ack            = if_ack_q;
  assign ls_ack            = ls_ack_q;
  assign if_rdata          = if_rdata_q;
  assign ls_rdata          = ls_rdata_q;

endmodule
